// File: rtl/line_rasterizer_pkg.sv
// Shared types, widths and helpers for the Bresenham line rasterizer.
package line_rasterizer_pkg;

    localparam int unsigned HRES_DEFAULT = 1024;
    localparam int unsigned VRES_DEFAULT = 768;
    localparam int unsigned X_W          = 11;
    localparam int unsigned Y_W          = 10;
    localparam int unsigned ADDR_W       = 20;
    localparam int unsigned ERR_W        = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PLOT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Linear frame-buffer address of a pixel for a given row pitch.
    function automatic logic [ADDR_W-1:0] pixel_addr(
        input logic [X_W-1:0]    x,
        input logic [Y_W-1:0]    y,
        input logic [ADDR_W-1:0] pitch
    );
        return ADDR_W'(y) * pitch + ADDR_W'(x);
    endfunction

    // True when the pixel lies inside the visible frame.
    function automatic logic in_frame(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y,
        input int unsigned    hres,
        input int unsigned    vres
    );
        return (32'(x) < hres) && (32'(y) < vres);
    endfunction

endpackage

// File: rtl/line_rasterizer_step.sv
// One Bresenham step: doubled-error compares and err/x/y update.
module line_step
    import line_rasterizer_pkg::*;
(
    input  logic signed [ERR_W-1:0] err,
    input  logic signed [ERR_W-1:0] dx,
    input  logic signed [ERR_W-1:0] dy,
    input  logic        [X_W-1:0]   cur_x,
    input  logic        [Y_W-1:0]   cur_y,
    input  logic                    sx_neg,
    input  logic                    sy_neg,
    output logic signed [ERR_W-1:0] next_err,
    output logic        [X_W-1:0]   next_x,
    output logic        [Y_W-1:0]   next_y
);

    logic signed [ERR_W-1:0] e2_s;
    logic                    step_x_s;
    logic                    step_y_s;

    // Both axes may step in the same cycle; their error terms simply add.
    always_comb begin
        e2_s     = err <<< 1;
        step_x_s = (e2_s >= dy);
        step_y_s = (e2_s <= dx);
        next_err = err;
        next_x   = cur_x;
        next_y   = cur_y;
        if (step_x_s) begin
            next_err = next_err + dy;
            if (sx_neg) begin
                next_x = cur_x - 11'd1;
            end else begin
                next_x = cur_x + 11'd1;
            end
        end else begin
            next_x = cur_x;
        end
        if (step_y_s) begin
            next_err = next_err + dx;
            if (sy_neg) begin
                next_y = cur_y - 10'd1;
            end else begin
                next_y = cur_y + 10'd1;
            end
        end else begin
            next_y = cur_y;
        end
    end

endmodule

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer writing one pixel per accepted frame-buffer write.
module line_rasterizer
    import line_rasterizer_pkg::*;
#(
    parameter logic [7:0]  COLOR = 8'hFF,
    parameter int unsigned HRES  = HRES_DEFAULT,
    parameter int unsigned VRES  = VRES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [X_W-1:0]    start_x,
    input  logic [Y_W-1:0]    start_y,
    input  logic [X_W-1:0]    end_x,
    input  logic [Y_W-1:0]    end_y,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready
);

    localparam logic [ADDR_W-1:0] PITCH = ADDR_W'(HRES);

    state_t                  state_r;
    logic [X_W-1:0]          x0_r, x1_r, cur_x_r;
    logic [Y_W-1:0]          y0_r, y1_r, cur_y_r;
    logic signed [ERR_W-1:0] dx_r, dy_r, err_r;
    logic                    sx_neg_r, sy_neg_r;
    logic                    busy_r, done_r, wr_en_r;
    logic [ADDR_W-1:0]       wr_addr_r;
    logic [7:0]              wr_data_r;

    logic [X_W-1:0]          dx_abs_s;
    logic [Y_W-1:0]          dy_abs_s;
    logic signed [ERR_W-1:0] setup_dx_s, setup_dy_s, setup_err_s;
    logic signed [ERR_W-1:0] next_err_s;
    logic [X_W-1:0]          next_x_s;
    logic [Y_W-1:0]          next_y_s;
    logic                    at_end_s, start_vis_s, next_vis_s, advance_s;

    assign busy    = busy_r;
    assign done    = done_r;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;

    line_step u_step (
        .err      (err_r),
        .dx       (dx_r),
        .dy       (dy_r),
        .cur_x    (cur_x_r),
        .cur_y    (cur_y_r),
        .sx_neg   (sx_neg_r),
        .sy_neg   (sy_neg_r),
        .next_err (next_err_s),
        .next_x   (next_x_s),
        .next_y   (next_y_s)
    );

    // Setup deltas from the latched endpoints; dy is kept negative as in Bresenham.
    always_comb begin
        if (x1_r >= x0_r) begin
            dx_abs_s = x1_r - x0_r;
        end else begin
            dx_abs_s = x0_r - x1_r;
        end
        if (y1_r >= y0_r) begin
            dy_abs_s = y1_r - y0_r;
        end else begin
            dy_abs_s = y0_r - y1_r;
        end
        setup_dx_s  = $signed({2'b00, dx_abs_s});
        setup_dy_s  = 13'sd0 - $signed({3'b000, dy_abs_s});
        setup_err_s = setup_dx_s + setup_dy_s;
        at_end_s    = (cur_x_r == x1_r) && (cur_y_r == y1_r);
        start_vis_s = in_frame(x0_r, y0_r, HRES, VRES);
        next_vis_s  = in_frame(next_x_s, next_y_s, HRES, VRES);
        // Off-frame points carry no write, so they advance without a handshake.
        advance_s   = !wr_en_r || wr_ready;
    end

    // Line FSM with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= 8'h00;
            x0_r      <= {X_W{1'b0}};
            x1_r      <= {X_W{1'b0}};
            cur_x_r   <= {X_W{1'b0}};
            y0_r      <= {Y_W{1'b0}};
            y1_r      <= {Y_W{1'b0}};
            cur_y_r   <= {Y_W{1'b0}};
            dx_r      <= 13'sd0;
            dy_r      <= 13'sd0;
            err_r     <= 13'sd0;
            sx_neg_r  <= 1'b0;
            sy_neg_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        x0_r    <= start_x;
                        y0_r    <= start_y;
                        x1_r    <= end_x;
                        y1_r    <= end_y;
                        busy_r  <= 1'b1;
                        state_r <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    dx_r      <= setup_dx_s;
                    dy_r      <= setup_dy_s;
                    err_r     <= setup_err_s;
                    sx_neg_r  <= (x1_r < x0_r);
                    sy_neg_r  <= (y1_r < y0_r);
                    cur_x_r   <= x0_r;
                    cur_y_r   <= y0_r;
                    wr_en_r   <= start_vis_s;
                    wr_addr_r <= start_vis_s ? pixel_addr(x0_r, y0_r, PITCH) : {ADDR_W{1'b0}};
                    wr_data_r <= start_vis_s ? COLOR : 8'h00;
                    state_r   <= ST_PLOT;
                end
                ST_PLOT: begin
                    if (advance_s) begin
                        if (at_end_s) begin
                            wr_en_r   <= 1'b0;
                            wr_addr_r <= {ADDR_W{1'b0}};
                            wr_data_r <= 8'h00;
                            state_r   <= ST_DONE;
                        end else begin
                            err_r     <= next_err_s;
                            cur_x_r   <= next_x_s;
                            cur_y_r   <= next_y_s;
                            wr_en_r   <= next_vis_s;
                            wr_addr_r <= next_vis_s ? pixel_addr(next_x_s, next_y_s, PITCH) : {ADDR_W{1'b0}};
                            wr_data_r <= next_vis_s ? COLOR : 8'h00;
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    wr_en_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/line_rasterizer.md
LINE_RASTERIZER -- requirements
Module: line_rasterizer

Interface
REQ-001 Parameter COLOR, default 8'hFF, is the pixel value written for every plotted point.
REQ-002 Parameter HRES, default 1024, is the frame width in pixels and the address row pitch.
REQ-003 Parameter VRES, default 768, is the frame height in pixels.
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to draw a line; sampled only in IDLE.
REQ-007 start_x, end_x  in  11 each  unsigned endpoint x coordinates.
REQ-008 start_y, end_y  in  10 each  unsigned endpoint y coordinates.
REQ-009 busy  out  1  high from the cycle after start is accepted until done is asserted.
REQ-010 done  out  1  one-cycle pulse after the last pixel write is accepted.
REQ-011 wr_en  out  1  frame-buffer write request.
REQ-012 wr_addr  out  20  write address, y*HRES + x.
REQ-013 wr_data  out  8  equals COLOR whenever wr_en is high.
REQ-014 wr_ready  in  1  frame buffer accepts the write in any cycle where wr_en and wr_ready are both high.

Function
REQ-015 The state machine SHALL have the states IDLE, SETUP, PLOT and DONE.
REQ-016 IDLE with start=1 SHALL latch all four coordinates and go to SETUP; start in any other state SHALL be ignored.
REQ-017 SETUP (one cycle) SHALL compute dx=|end_x-start_x|, dy=-|end_y-start_y|, sx/sy=+1 or -1, err=dx+dy, cur=(start_x,start_y), then go to PLOT.
REQ-018 Internal arithmetic SHALL be signed 13-bit (err, dx, dy, and the doubled error e2=2*err), so that no intermediate value overflows.
REQ-019 In PLOT, wr_en SHALL be high with wr_addr=cur_y*HRES+cur_x, and it SHALL hold stable until accepted.
REQ-020 On acceptance, if cur equals the end point, the next state SHALL be DONE.
REQ-021 Otherwise, with e2=2*err: if e2>=dy then err+=dy and cur_x+=sx; if e2<=dx then err+=dx and cur_y+=sy. Both updates SHALL apply in the same cycle when both conditions hold.
REQ-022 A point with cur_x>=HRES or cur_y>=VRES SHALL not assert wr_en and SHALL advance (or finish) in one cycle as if accepted.
REQ-023 DONE SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-024 The first wr_en SHALL be asserted two cycles after the start cycle.
REQ-025 Exactly max(|dx|,|dy|)+1 points SHALL be stepped per line, with no duplicates.
REQ-026 With wr_ready tied high, a line of N points SHALL complete in N+3 cycles from start to done inclusive.
REQ-027 A zero-length line (start equals end) SHALL produce exactly one write.
REQ-028 The block SHALL accept a new start on the cycle after done (IDLE).

Reset
REQ-029 Reset SHALL force IDLE and drive busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0 on the next edge.
REQ-030 Reset mid-line SHALL abandon the line immediately: no further writes and no done pulse.
REQ-031 Reset SHALL take priority over a simultaneous start.

Structure
REQ-032 A shared package SHALL hold the state enum, the HRES/VRES defaults, the coordinate widths (11/10), the address width (20) and the error width (13).
REQ-033 The step arithmetic (e2 compare, err/x/y update) SHALL be one combinational sub-module, line_step, instantiated once.

Verification
REQ-034 The bench SHALL cover this case: (10,20)->(14,20) with wr_ready=1 -> addresses 20490..20494 on consecutive cycles, first write 2 cycles after start, done 8 cycles after start.
REQ-035 The bench SHALL cover this case: (0,0)->(3,3) -> addresses 0, 1025, 2050, 3075, then done.
REQ-036 The bench SHALL cover this case: (5,5)->(5,5) -> a single write at 5125, done 2 cycles later.
REQ-037 The bench SHALL cover this case: (7,2)->(0,0) -> 8 writes, x decreasing 7..0 each step, y pattern matching the reference Bresenham model, final address 0.
REQ-038 The bench SHALL cover this case: wr_ready low for 3 cycles on the second point -> wr_en/wr_addr held steady, no skipped or repeated pixel, and a second start during busy ignored.
REQ-039 The bench SHALL cover this case: reset asserted on the third write cycle -> wr_en=0 and busy=0 next cycle, no done; a fresh start then draws normally.
